// File: rtl/hir_banked_mem_model_if.sv
// -----------------------------------------------------------------------------
// hir_banked_mem_model_if
// Bundles the per-bank read/write ports and the control/status signals of the
// banked memory responder.
//   master : kernel/bench side (drives strobes, addresses, write data, init_start)
//   slave  : memory model side (drives rd_data, rd_valid, init_busy, wr_count, err)
// Bank b occupies [b*ADDR_W +: ADDR_W] of the address vectors and
// [b*DATA_W +: DATA_W] of the data vectors.
// -----------------------------------------------------------------------------
interface hir_banked_mem_model_if #(
  parameter int NUM_BANKS = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_BANKS-1:0]        rd_en;
  logic [NUM_BANKS*ADDR_W-1:0] rd_addr;
  logic [NUM_BANKS*DATA_W-1:0] rd_data;
  logic [NUM_BANKS-1:0]        rd_valid;
  logic [NUM_BANKS-1:0]        wr_en;
  logic [NUM_BANKS*ADDR_W-1:0] wr_addr;
  logic [NUM_BANKS*DATA_W-1:0] wr_data;
  logic                        init_start;
  logic                        init_busy;
  logic [31:0]                 wr_count;
  logic                        err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, init_start,
    input  rd_data, rd_valid, init_busy, wr_count, err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, init_start,
    output rd_data, rd_valid, init_busy, wr_count, err
  );
endinterface

// File: rtl/hir_banked_mem_model.sv
// -----------------------------------------------------------------------------
// hir_banked_mem_model
// Banked memory responder for HIR kernel benches. NUM_BANKS independent banks,
// each with one pipelined read port (RD_LATENCY cycles, 1..4) and one write port.
// After reset (or init_start in READY) every bank is filled in parallel with a
// deterministic pattern for DEPTH cycles; ports are ignored meanwhile and any
// strobe during the fill sets the sticky err flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of hir_banked_mem_model_if (rd/wr ports, init_start,
//           init_busy, wr_count, err)
// -----------------------------------------------------------------------------
module hir_banked_mem_model #(
  parameter int NUM_BANKS  = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int INIT_MODE  = 0,
  parameter int SENTINEL   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hir_banked_mem_model_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Pattern arithmetic is done at least 32 bits wide, then truncated.
  localparam int PW = (DATA_W > 32) ? DATA_W : 32;
  localparam logic [DATA_W-1:0] SENT_W = DATA_W'(SENTINEL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic [ADDR_W-1:0] ptr_r;
  logic init_busy_r;
  logic err_r;
  logic [31:0] wr_count_r;

  logic [DATA_W-1:0] mem_r [NUM_BANKS][DEPTH];

  logic [NUM_BANKS-1:0]        rd_acc_s;
  logic [NUM_BANKS-1:0]        wr_acc_s;
  logic [NUM_BANKS*DATA_W-1:0] rd_stage0_s;
  logic [32:0]                 wr_sum_s;
  logic                        port_err_s;

  // Valid bit and data move together; data lanes carry SENTINEL when invalid.
  logic [NUM_BANKS-1:0]        vld_pipe_r [RD_LATENCY];
  logic [NUM_BANKS*DATA_W-1:0] dat_pipe_r [RD_LATENCY];

  function automatic logic [DATA_W-1:0] pattern(input int bank, input int addr);
    logic [PW-1:0] v;
    case (INIT_MODE)
      32'd0:   v = PW'(addr) + PW'(bank) + PW'(32'd1);
      32'd1:   v = {PW{1'b0}};
      32'd2:   v = PW'(bank) * PW'(DEPTH) + PW'(addr);
      default: v = {PW{1'b0}};
    endcase
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [32:0] popcount(input logic [NUM_BANKS-1:0] v);
    logic [32:0] c;
    c = 33'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      c = c + {32'd0, v[i]};
    end
    return c;
  endfunction

  // Next-state decode: fill ends after the last address is written.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (ptr_r == LAST_ADDR) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_READY: begin
        if (bus.init_start) begin
          state_next_s = ST_INIT;
        end else begin
          state_next_s = ST_READY;
        end
      end
      default: state_next_s = ST_INIT;
    endcase
  end

  // Port qualification, read-stage-0 data, write count sum and INIT misuse.
  always_comb begin
    rd_acc_s    = {NUM_BANKS{1'b0}};
    wr_acc_s    = {NUM_BANKS{1'b0}};
    rd_stage0_s = {NUM_BANKS{SENT_W}};
    if (state_r == ST_READY) begin
      rd_acc_s = bus.rd_en;
      wr_acc_s = bus.wr_en;
    end else begin
      rd_acc_s = {NUM_BANKS{1'b0}};
      wr_acc_s = {NUM_BANKS{1'b0}};
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_acc_s[b]) begin
        rd_stage0_s[b*DATA_W +: DATA_W] = mem_r[b][bus.rd_addr[b*ADDR_W +: ADDR_W]];
      end else begin
        rd_stage0_s[b*DATA_W +: DATA_W] = SENT_W;
      end
    end
    wr_sum_s   = {1'b0, wr_count_r} + popcount(wr_acc_s);
    port_err_s = (state_r == ST_INIT) && ((|bus.rd_en) || (|bus.wr_en));
  end

  // FSM state, fill pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      ptr_r       <= {ADDR_W{1'b0}};
      init_busy_r <= 1'b1;
      err_r       <= 1'b0;
      wr_count_r  <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      init_busy_r <= (state_next_s == ST_INIT);
      // Pointer parks at 0 in READY so a re-fill starts from the first word.
      if (state_r == ST_INIT) begin
        ptr_r <= ptr_r + ADDR_W'(1'b1);
      end else begin
        ptr_r <= {ADDR_W{1'b0}};
      end
      err_r <= err_r | port_err_s;
      if (wr_sum_s[32]) begin
        wr_count_r <= 32'hFFFF_FFFF;
      end else begin
        wr_count_r <= wr_sum_s[31:0];
      end
    end
  end

  // Storage: fill writes every bank in parallel; it is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state_r == ST_INIT) begin
        mem_r[b][ptr_r] <= pattern(b, int'(ptr_r));
      end else if (wr_acc_s[b]) begin
        mem_r[b][bus.wr_addr[b*ADDR_W +: ADDR_W]] <= bus.wr_data[b*DATA_W +: DATA_W];
      end
    end
  end

  // Read pipeline: reads sample pre-write storage, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        vld_pipe_r[s] <= {NUM_BANKS{1'b0}};
        dat_pipe_r[s] <= {NUM_BANKS{SENT_W}};
      end
    end else begin
      vld_pipe_r[0] <= rd_acc_s;
      dat_pipe_r[0] <= rd_stage0_s;
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_pipe_r[s] <= vld_pipe_r[s-1];
        dat_pipe_r[s] <= dat_pipe_r[s-1];
      end
    end
  end

  assign bus.rd_valid  = vld_pipe_r[RD_LATENCY-1];
  assign bus.rd_data   = dat_pipe_r[RD_LATENCY-1];
  assign bus.init_busy = init_busy_r;
  assign bus.wr_count  = wr_count_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_hir_banked_mem_model.sv
// -----------------------------------------------------------------------------
// tb_hir_banked_mem_model
// Two instances share clk/rst_n: dut_a (RD_LATENCY=1) and dut_b (RD_LATENCY=3).
// Read requests push {bank, data, due cycle} into a per-instance queue; a
// negedge monitor pops and compares whenever rd_valid is seen, and also checks
// that idle banks show the sentinel. Status outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_hir_banked_mem_model;

  localparam int NB = 16;
  localparam int AW = 4;
  localparam int DW = 32;

  typedef struct {
    int          bank;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  exp_t tmp;

  hir_banked_mem_model_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  hir_banked_mem_model_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  hir_banked_mem_model #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1),
                         .INIT_MODE(0), .SENTINEL(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  hir_banked_mem_model #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3),
                         .INIT_MODE(0), .SENTINEL(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifa.rd_valid !== 16'h0000) begin
      for (int b = 0; b < NB; b++) begin
        if (ifa.rd_valid[b] === 1'b1) begin
          n_checks++;
          if (qa.size() == 0) begin
            n_fail++;
            $display("FAIL a_unexpected_valid: bank %0d data %0h with no read pending", b, ifa.rd_data[b*DW +: DW]);
          end else begin
            ea = qa.pop_front();
            if (ea.bank != b || ifa.rd_data[b*DW +: DW] !== ea.data || ea.due != cyc) begin
              n_fail++;
              $display("FAIL a_read: got bank %0d data %0h cycle %0d expected bank %0d data %0h cycle %0d",
                       b, ifa.rd_data[b*DW +: DW], cyc, ea.bank, ea.data, ea.due);
            end
          end
        end else begin
          chk($sformatf("a_idle_sentinel_b%0d", b), ifa.rd_data[b*DW +: DW], 32'd255);
        end
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifb.rd_valid !== 16'h0000) begin
      for (int b = 0; b < NB; b++) begin
        if (ifb.rd_valid[b] === 1'b1) begin
          n_checks++;
          if (qb.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected_valid: bank %0d data %0h with no read pending", b, ifb.rd_data[b*DW +: DW]);
          end else begin
            eb = qb.pop_front();
            if (eb.bank != b || ifb.rd_data[b*DW +: DW] !== eb.data || eb.due != cyc) begin
              n_fail++;
              $display("FAIL b_read: got bank %0d data %0h cycle %0d expected bank %0d data %0h cycle %0d",
                       b, ifb.rd_data[b*DW +: DW], cyc, eb.bank, eb.data, eb.due);
            end
          end
        end else begin
          chk($sformatf("b_idle_sentinel_b%0d", b), ifb.rd_data[b*DW +: DW], 32'd255);
        end
      end
    end
  end

  task automatic read_a(input int b, input int addr, input logic [31:0] exp);
    @(negedge clk);
    ifa.rd_en = '0;
    ifa.rd_en[b] = 1'b1;
    ifa.rd_addr[b*AW +: AW] = AW'(addr);
    tmp.bank = b; tmp.data = exp; tmp.due = cyc + 1;
    qa.push_back(tmp);
    @(negedge clk);
    ifa.rd_en = '0;
  endtask

  // Counts negedge samples with init_busy high on dut_a; optionally pokes
  // ports and init_start a few cycles into the fill.
  task automatic count_busy(input string name, input bit inject);
    int n;
    n = 0;
    while (ifa.init_busy === 1'b1 && n < 40) begin
      if (inject && n == 3) begin
        ifa.rd_en[1]   = 1'b1;
        ifa.wr_en[0]   = 1'b1;
        ifa.init_start = 1'b1;
      end else begin
        ifa.rd_en      = '0;
        ifa.wr_en      = '0;
        ifa.init_start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    chk(name, n, 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    ifa.rd_en = '0; ifa.rd_addr = '0; ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.init_start = 1'b0;
    ifb.rd_en = '0; ifb.rd_addr = '0; ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.init_start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rd_valid", {16'd0, ifa.rd_valid}, 32'd0);
    chk("rst_rd_data_b7", ifa.rd_data[7*DW +: DW], 32'd255);
    chk("rst_wr_count", ifa.wr_count, 32'd0);
    chk("rst_err", {31'd0, ifa.err}, 32'd0);
    chk("rst_init_busy", {31'd0, ifa.init_busy}, 32'd1);

    // 1: INIT length, then bank 3 addr 5 -> 9 after one cycle
    rst_n = 1'b1;
    count_busy("init_busy_cycles", 1'b0);
    chk("b_ready_after_init", {31'd0, ifb.init_busy}, 32'd0);
    read_a(3, 5, 32'd9);

    // 2: back-to-back reads on the latency-3 instance
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ifb.rd_en[0] = 1'b1;
      ifb.rd_addr[0 +: AW] = AW'(i);
      tmp.bank = 0; tmp.data = 32'(i + 1); tmp.due = cyc + 3;
      qb.push_back(tmp);
      @(negedge clk);
    end
    ifb.rd_en = '0;
    repeat (4) @(negedge clk);

    // 3: all banks write addr 7
    ifa.wr_en = '1;
    for (int b = 0; b < NB; b++) begin
      ifa.wr_addr[b*AW +: AW] = 4'd7;
      ifa.wr_data[b*DW +: DW] = 32'hA0 + 32'(b);
    end
    @(negedge clk);
    ifa.wr_en = '0;
    chk("wr_count_16", ifa.wr_count, 32'd16);
    read_a(15, 7, 32'hAF);
    read_a(0, 7, 32'hA0);

    // 4: same-cycle write and read on bank 2 addr 4
    @(negedge clk);
    ifa.wr_en[2] = 1'b1; ifa.wr_addr[2*AW +: AW] = 4'd4; ifa.wr_data[2*DW +: DW] = 32'h0000_DEAD;
    ifa.rd_en[2] = 1'b1; ifa.rd_addr[2*AW +: AW] = 4'd4;
    tmp.bank = 2; tmp.data = 32'd7; tmp.due = cyc + 1;
    qa.push_back(tmp);
    @(negedge clk);
    ifa.wr_en = '0; ifa.rd_en = '0;
    read_a(2, 4, 32'h0000_DEAD);
    chk("wr_count_17", ifa.wr_count, 32'd17);
    chk("err_clean_ready", {31'd0, ifa.err}, 32'd0);

    // 5: re-fill with strobes and a redundant init_start mid-fill
    ifa.init_start = 1'b1;
    @(negedge clk);
    ifa.init_start = 1'b0;
    count_busy("refill_busy_cycles", 1'b1);
    chk("err_sticky", {31'd0, ifa.err}, 32'd1);
    chk("wr_count_kept", ifa.wr_count, 32'd17);
    chk("b_err_clear", {31'd0, ifb.err}, 32'd0);
    read_a(2, 4, 32'd7);
    read_a(0, 7, 32'd8);

    // 6a: reset with reads in flight on dut_b
    @(negedge clk);
    ifb.rd_en[5] = 1'b1; ifb.rd_addr[5*AW +: AW] = 4'd3;
    @(negedge clk);
    ifb.rd_addr[5*AW +: AW] = 4'd4;
    @(negedge clk);
    ifb.rd_en = '0;
    @(posedge clk);
    #1;
    chk("inflight_valid_before_rst", {31'd0, ifb.rd_valid[5]}, 32'd1);
    chk("inflight_data_before_rst", ifb.rd_data[5*DW +: DW], 32'd9);
    rst_n = 1'b0;
    #1;
    chk("rst_clears_valid", {16'd0, ifb.rd_valid}, 32'd0);
    chk("rst_sentinel_b5", ifb.rd_data[5*DW +: DW], 32'd255);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 6b: reset again at ptr=8, then a full fill must follow
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midinit_rst_err", {31'd0, ifa.err}, 32'd0);
    chk("midinit_rst_count", ifa.wr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("reinit_busy_cycles", 1'b0);
    chk("reinit_err", {31'd0, ifa.err}, 32'd0);
    chk("reinit_wr_count", ifa.wr_count, 32'd0);
    read_a(2, 4, 32'd7);

    repeat (6) @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
